pll_lock_sequencer: RTL and testbench

- Controls the on-chip rPLL and consumes its LOCK output. Produces the clean, synchronously released system reset for the PLL-clocked logic.
- Runs on the PLL reference clock (27 MHz board oscillator), so it keeps operating while the PLL is unlocked.
- Drives the PLL RESET pin, waits for lock, checks lock stability, re-trains on timeout or lock loss, and keeps saturating retry and loss counters for debug LEDs and UART status.

---
 rtl/pll_lock_sequencer.sv | 113 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Sequences the rPLL reset, qualifies its lock with a stability window, and
// releases the PLL-domain system reset. Runs from the reference clock.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 2700000,
  parameter int STABLE_CYCLES = 27000,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             locked,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state_o
);

  localparam int MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [TIMER_W-1:0]     timer;
  logic                   retry_inc, loss_inc;

  // pll_lock is asynchronous to clk; only the last stage is ever consumed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values;
      // blocking here would collapse the shift chain into a single stage.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    next_state = state;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (timer == RST_LAST) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over a retry.
        if (lock_s) begin
          next_state = ST_STABILIZE;
        end else if (timer == TIMEOUT_LAST) begin
          next_state = ST_PLL_RST;
          retry_inc  = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s)                   next_state = ST_WAIT_LOCK;
        else if (timer == STABLE_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          next_state = ST_WAIT_LOCK;
          loss_inc   = 1'b1;
        end
      end
      default: next_state = ST_PLL_RST;
    endcase
  end

  // Outputs are registered from next_state so they change on the transition
  // edge itself and stay glitch-free toward the PLL and the system reset tree.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= ST_PLL_RST;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= next_state;
      pll_rst   <= (next_state == ST_PLL_RST);
      sys_rst_n <= (next_state == ST_RUN);
      locked    <= (next_state == ST_RUN);
      if (next_state != state)  timer <= '0;
      else if (state != ST_RUN) timer <= timer + 1'b1;
      if (retry_inc && (retry_cnt != '1)) retry_cnt <= retry_cnt + 1'b1;
      if (loss_inc && (loss_cnt != '1))   loss_cnt  <= loss_cnt + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer using shortened timing parameters.
module tb_pll_lock_sequencer;

  localparam int SYNC_STAGES   = 2;
  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 4;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             pll_lock = 1'b0;
  logic             pll_rst, sys_rst_n, locked;
  logic [CNT_W-1:0] retry_cnt, loss_cnt;
  logic [1:0]       state_o;

  int tests_run = 0;
  int tests_failed = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .arst_n(arst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n), .locked(locked), .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Outside RUN the system reset and locked flag must never be released.
  always @(negedge clk) begin
    if (arst_n) begin
      tests_run++;
      if (state_o != 2'd3 && (sys_rst_n !== 1'b0 || locked !== 1'b0)) begin
        tests_failed++;
        $display("FAIL invariant: state=%0d sys_rst_n=%b locked=%b, required sys_rst_n=0 locked=0",
                 state_o, sys_rst_n, locked);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 3 ns after an edge; the next posedge is cycle 1.
  task automatic apply_reset;
    arst_n   = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    arst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    tests_run++;
    if ({pll_rst, sys_rst_n, locked} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_flags: got pll_rst/sys_rst_n/locked=%b, required 100",
               {pll_rst, sys_rst_n, locked});
    end
    tests_run++;
    if (retry_cnt !== 4'd0 || loss_cnt !== 4'd0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got retry=%0d loss=%0d state=%0d, required 0 0 0",
               retry_cnt, loss_cnt, state_o);
    end
  endtask

  task automatic test_bring_up;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      tests_run++;
      if (pll_rst !== (i < 4) || state_o !== ((i < 4) ? 2'd0 : 2'd1)) begin
        tests_failed++;
        $display("FAIL bringup_pulse c%0d: got pll_rst=%b state=%0d, required pll_rst=%b state=%0d",
                 i, pll_rst, state_o, (i < 4), (i < 4) ? 0 : 1);
      end
    end
    pll_lock = 1'b1;
    for (int i = 10; i <= 20; i++) begin
      tick(1);
      tests_run++;
      if (locked !== (i == 20) || sys_rst_n !== (i == 20)) begin
        tests_failed++;
        $display("FAIL bringup_lock c%0d: got locked=%b sys_rst_n=%b, required %b",
                 i, locked, sys_rst_n, (i == 20));
      end
    end
    tests_run++;
    if (state_o !== 2'd3 || retry_cnt !== 4'd0 || pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL bringup_final: got state=%0d retry=%0d pll_rst=%b, required 3 0 0",
               state_o, retry_cnt, pll_rst);
    end
  endtask

  task automatic test_timeout;
    int exp_before, exp_after;
    apply_reset();
    tick(23);
    for (int k = 1; k <= 17; k++) begin
      exp_before = (k - 1 > 15) ? 15 : k - 1;
      exp_after  = (k > 15) ? 15 : k;
      tests_run++;
      if (retry_cnt !== 4'(exp_before) || state_o !== 2'd1 || pll_rst !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_pre k%0d: got retry=%0d state=%0d pll_rst=%b, required %0d 1 0",
                 k, retry_cnt, state_o, pll_rst, exp_before);
      end
      tick(1);
      tests_run++;
      if (retry_cnt !== 4'(exp_after) || state_o !== 2'd0 || pll_rst !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_post k%0d: got retry=%0d state=%0d pll_rst=%b, required %0d 0 1",
                 k, retry_cnt, state_o, pll_rst, exp_after);
      end
      tick(3);
      tests_run++;
      if (pll_rst !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_pulse_end k%0d: got pll_rst=%b, required 1", k, pll_rst);
      end
      tick(1);
      tests_run++;
      if (pll_rst !== 1'b0 || state_o !== 2'd1) begin
        tests_failed++;
        $display("FAIL timeout_pulse_off k%0d: got pll_rst=%b state=%0d, required 0 1",
                 k, pll_rst, state_o);
      end
      tick(19);
    end
  endtask

  // Ends in RUN, 1 ns after cycle 27; test_lock_loss continues from there.
  task automatic test_unstable;
    apply_reset();
    tick(9);
    pll_lock = 1'b1;
    tick(6);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    tests_run++;
    if (state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL unstable_pre: got state=%0d, required 2", state_o);
    end
    tick(1);
    tests_run++;
    if (state_o !== 2'd1 || sys_rst_n !== 1'b0 || retry_cnt !== 4'd0 || loss_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL unstable_drop: got state=%0d sys_rst_n=%b retry=%0d loss=%0d, required 1 0 0 0",
               state_o, sys_rst_n, retry_cnt, loss_cnt);
    end
    tick(1);
    tests_run++;
    if (state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL unstable_reenter: got state=%0d, required 2", state_o);
    end
    tick(7);
    tests_run++;
    if (state_o !== 2'd2 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL unstable_early: got state=%0d locked=%b, required 2 0", state_o, locked);
    end
    tick(1);
    tests_run++;
    if (state_o !== 2'd3 || locked !== 1'b1 || sys_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL unstable_run: got state=%0d locked=%b sys_rst_n=%b, required 3 1 1",
               state_o, locked, sys_rst_n);
    end
  endtask

  task automatic test_lock_loss;
    pll_lock = 1'b0;
    tick(2);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL loss_hold: got locked=%b, required 1", locked);
    end
    tick(1);
    tests_run++;
    if (locked !== 1'b0 || sys_rst_n !== 1'b0 || loss_cnt !== 4'd1 || state_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL loss_drop: got locked=%b sys_rst_n=%b loss=%0d state=%0d, required 0 0 1 1",
               locked, sys_rst_n, loss_cnt, state_o);
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      tests_run++;
      if (pll_rst !== 1'b0 || locked !== 1'b0) begin
        tests_failed++;
        $display("FAIL loss_relock c%0d: got pll_rst=%b locked=%b, required 0 0", i, pll_rst, locked);
      end
    end
    tick(1);
    tests_run++;
    if (state_o !== 2'd3 || locked !== 1'b1 || loss_cnt !== 4'd1 || retry_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL loss_run: got state=%0d locked=%b loss=%0d retry=%0d, required 3 1 1 0",
               state_o, locked, loss_cnt, retry_cnt);
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    tick(24);
    tests_run++;
    if (retry_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL areset_setup: got retry=%0d, required 1", retry_cnt);
    end
    tick(6);
    pll_lock = 1'b1;
    tick(5);
    tests_run++;
    if (state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL areset_stab: got state=%0d, required 2", state_o);
    end
    #2;
    arst_n = 1'b0;
    #1;
    tests_run++;
    if ({pll_rst, sys_rst_n, locked} !== 3'b100 || retry_cnt !== 4'd0 ||
        loss_cnt !== 4'd0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got flags=%b retry=%0d loss=%0d state=%0d, required 100 0 0 0",
               {pll_rst, sys_rst_n, locked}, retry_cnt, loss_cnt, state_o);
    end
    tick(2);
    #2;
    arst_n = 1'b1;
    tick(1);
    tests_run++;
    if (state_o !== 2'd0 || pll_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_restart: got state=%0d pll_rst=%b, required 0 1", state_o, pll_rst);
    end
    tick(3);
    tests_run++;
    if (state_o !== 2'd1 || pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_wait: got state=%0d pll_rst=%b, required 1 0", state_o, pll_rst);
    end
  endtask

  // lock_s rises just as the WAIT_LOCK timer sits at LOCK_TIMEOUT-1.
  task automatic test_simultaneous;
    apply_reset();
    tick(21);
    pll_lock = 1'b1;
    tick(2);
    tests_run++;
    if (state_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL simul_pre: got state=%0d, required 1", state_o);
    end
    tick(1);
    tests_run++;
    if (state_o !== 2'd2 || retry_cnt !== 4'd0 || pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_post: got state=%0d retry=%0d pll_rst=%b, required 2 0 0",
               state_o, retry_cnt, pll_rst);
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_timeout();
    test_unstable();
    test_lock_loss();
    test_async_reset();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
